// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and receiver state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_OVERSAMPLE  = 16;
    localparam int UART_SAMPLE_TICK = 7;
    localparam int UART_DATA_BITS   = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync
// Description : Flop-chain synchroniser for an asynchronous single-bit input.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (SYNC_STAGES <= 1) begin : g_single
            logic r_q;

            always_ff @(posedge clk) begin
                if (rst) r_q <= RESET_VALUE;
                else     r_q <= d;
            end

            assign q = r_q;
        end else begin : g_chain
            logic [SYNC_STAGES-1:0] r_chain;

            always_ff @(posedge clk) begin
                if (rst) r_chain <= {SYNC_STAGES{RESET_VALUE}};
                else     r_chain <= {r_chain[SYNC_STAGES-2:0], d};
            end

            assign q = r_chain[SYNC_STAGES-1];
        end
    endgenerate

endmodule : uart_sync
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 UART receive path driven by a 16x oversampling strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int SAMPLE_TICK = UART_SAMPLE_TICK,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sck_rising_edge,
    input  logic                 sin,
    output logic                 receiver_busy,
    output logic                 rx_data_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_error
);

    localparam int c_tick_w = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int c_bit_w  = $clog2(DATA_BITS + 1);

    localparam logic [c_tick_w-1:0] c_tick_last   = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [c_tick_w-1:0] c_tick_sample = c_tick_w'(SAMPLE_TICK);
    localparam logic [c_bit_w-1:0]  c_bit_last    = c_bit_w'(DATA_BITS);

    uart_rx_state_t        r_state;
    uart_rx_state_t        w_state_next;
    logic [c_tick_w-1:0]   r_tick_cnt;
    logic [c_bit_w-1:0]    r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  r_rx_data;
    logic                  r_rx_data_valid;
    logic                  r_rx_error;

    logic w_sin_s;
    logic w_tick;
    logic w_sample;
    logic w_wrap;
    logic w_busy;
    logic w_shift;
    logic w_done;
    logic w_valid_set;
    logic w_err_set;

    uart_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sin),
        .q   (w_sin_s)
    );

    // Ticks arriving while disabled are discarded outright.
    assign w_tick   = sck_rising_edge & en;
    assign w_sample = w_tick & (r_tick_cnt == c_tick_sample);
    assign w_wrap   = w_tick & (r_tick_cnt == c_tick_last);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (!en) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:  if (w_tick && !w_sin_s) w_state_next = START;
                START: begin
                    if (w_sample && w_sin_s) w_state_next = IDLE;
                    else if (w_wrap)         w_state_next = DATA;
                end
                DATA:  if (w_wrap && (r_bit_cnt == c_bit_last)) w_state_next = STOP;
                STOP:  if (w_sample) w_state_next = w_sin_s ? IDLE : BREAK;
                BREAK: if (w_sin_s)  w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy      = (r_state != IDLE);
        w_shift     = (r_state == DATA) && w_sample;
        w_done      = (r_state == STOP) && w_sample;
        w_valid_set = w_done && w_sin_s;
        w_err_set   = w_done && !w_sin_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt      <= '0;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_rx_data       <= '0;
            r_rx_data_valid <= 1'b0;
            r_rx_error      <= 1'b0;
        end else begin
            r_rx_data_valid <= w_valid_set;
            r_rx_error      <= w_err_set;
            if (w_done) r_rx_data <= r_shift;

            if (!en) begin
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
                r_shift    <= '0;
            end else if (r_state == IDLE || r_state == BREAK) begin
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
            end else if (w_tick) begin
                if (w_wrap) begin
                    r_tick_cnt <= '0;
                    r_bit_cnt  <= r_bit_cnt + 1'b1;
                end else begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                end
                // Right shift so the first (LSB) bit lands at bit 0 after the last sample.
                if (w_shift) r_shift <= {w_sin_s, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    assign receiver_busy = w_busy;
    assign rx_data_valid = r_rx_data_valid;
    assign rx_data       = r_rx_data;
    assign rx_error      = r_rx_error;

endmodule : uart_receiver
`default_nettype wire
